trace_gen: RTL and testbench
============================

TRACE_GEN -- requirements
Module: trace_gen

Interface
REQ-001 SHALL have parameter: ID_INIT, 0, first instruction ID issued after reset (0..0x7FFF_FFFF).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: i_fire  in  1  new instruction enters stage I; i_pc  in  32  its PC; i_inst  in  32  its opcode.
REQ-005 SHALL have ports: x_adv, m_adv, r_adv  in  1 each  pipeline moves I->X, X->M, M->retire.
REQ-006 SHALL have ports: flush  in  1  kill contents of stages I and X.
REQ-007 SHALL have ports: rd_we  in  1, rd_addr  in  5, rd_wdata  in  32  writeback of the retiring instruction.
REQ-008 SHALL have ports: inst_v_i, inst_v_x, inst_v_m, inst_v_r  out  1  stage-entry / retire event pulses; ci, cx, cm, cr  out  32 (int)  IDs for those events.
REQ-009 SHALL have ports: valid  out  1, pc  out  32, inst  out  32  retired instruction; rdv  out  1, rd_x  out  5, rd_data  out  32  its writeback.
REQ-010 SHALL have ports: pcv  out  1, pc_x  out  32  redirect report; ovf_err  out  1  sticky protocol error.

Function
REQ-011 SHALL hold stage registers I, X, M, each {v, id, pc, inst}; all event outputs registered, one cycle after the causing edge's inputs.
REQ-012 SHALL on i_fire, when I empty or x_adv accepted same cycle, load I with next ID and pulse inst_v_i, ci=ID, then increment ID.
REQ-013 SHALL wrap ID from 0x7FFF_FFFF to 0.
REQ-014 SHALL on x_adv with I valid move I->X, pulse inst_v_x, cx=id; x_adv with I empty SHALL produce no event.
REQ-015 SHALL on m_adv with X valid move X->M, pulse inst_v_m, cm=id; likewise ignored if X empty.
REQ-016 SHALL on r_adv with M valid clear M, pulse inst_v_r and valid, cr=id, pc/inst from M, rdv=rd_we, rd_x=rd_addr, rd_data=rd_wdata.
REQ-017 SHALL process all advances in one cycle simultaneously (full shift), using pre-edge stage contents.
REQ-018 SHALL on i_fire while I valid and no x_adv drop the new instruction, keep ID unchanged, set ovf_err; same for x_adv into occupied X without m_adv, and m_adv into occupied M without r_adv.
REQ-019 SHALL on flush invalidate I and X after this cycle's moves out of them; an i_fire in the flush cycle SHALL be accepted (redirect target) and survive.
REQ-020 SHALL on flush pulse pcv with pc_x = i_pc when i_fire is set, else pcv stays low.
REQ-021 SHALL keep every pulse output low in cycles without its event; ci..cr, pc, inst, rd_* hold last value.

Reset
REQ-022 SHALL on reset low clear all stage valids, all pulse outputs, ovf_err, ci/cx/cm/cr, pc, inst, pc_x, rd_x, rd_data to 0, and load ID counter with ID_INIT.
REQ-023 SHALL when reset asserts mid-operation discard in-flight instructions with no events emitted.

Configuration
REQ-024 SHALL with TRACE_FLUSH_EN defined add outputs inst_v_f (1) and cf (32), pulsing once per flushed I/X entry (X before I if both, I's pulse in the following cycle).
REQ-025 SHALL without TRACE_FLUSH_EN omit those ports and discard flushed entries silently.

Structure
REQ-026 SHALL place stage entry struct trace_stage_t and ID_MAX (0x7FFF_FFFF) in shared package trace_pkg.
REQ-027 SHALL implement each stage register as sub-module trace_stage (load, clear, hold).

Verification
REQ-028 SHALL cover: reset, i_fire pc=0x100 inst=0x00500093, then x/m/r_adv on consecutive cycles -> ci=cx=cm=cr=0, valid with pc=0x100 four cycles after fire.
REQ-029 SHALL cover: ID_INIT=0x7FFF_FFFF, two i_fire with x_adv -> ci=0x7FFF_FFFF then 0.
REQ-030 SHALL cover: i_fire twice with no x_adv -> second dropped, ovf_err=1, next accepted ID unchanged.
REQ-031 SHALL cover: flush with I,X valid and i_fire pc=0x200 -> pcv=1, pc_x=0x200, new ID in I, no inst_v_x/m for killed IDs; with TRACE_FLUSH_EN, two inst_v_f pulses.
REQ-032 SHALL cover: r_adv with rd_we=1, rd_addr=5, rd_wdata=0xDEADBEEF -> rdv=1, rd_x=5, rd_data=0xDEADBEEF with valid.
REQ-033 SHALL cover: reset low with three instructions in flight -> all outputs 0, no further events after release.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the instruction trace generator: per-stage entry record,
// ID range limit and ID increment helper.
package trace_pkg;

    localparam logic [31:0] ID_MAX = 32'h7FFF_FFFF;

    typedef struct packed {
        logic        v;
        logic [31:0] id;
        logic [31:0] pc;
        logic [31:0] inst;
    } trace_stage_t;

    // IDs live in 0..ID_MAX and wrap back to zero.
    function automatic logic [31:0] next_id(input logic [31:0] id);
        return (id >= ID_MAX) ? 32'd0 : id + 32'd1;
    endfunction

endpackage

// File: rtl/trace_stage.sv
// One pipeline-stage trace register: load takes priority over clear,
// otherwise the entry holds. Clear only drops the valid bit.
module trace_stage
    import trace_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clr_i,
    input  trace_stage_t d_i,
    output trace_stage_t q_o
);

    trace_stage_t q_q;
    trace_stage_t q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (clr_i) begin
            q_d.v = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/trace_gen.sv
// Instruction trace generator for a 3-stage (I/X/M) pipeline with retire.
// Define TRACE_FLUSH_EN to add the inst_v_f/cf flushed-entry report.
module trace_gen
    import trace_pkg::*;
#(
    parameter logic [31:0] ID_INIT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_fire,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        x_adv,
    input  logic        m_adv,
    input  logic        r_adv,
    input  logic        flush,
    input  logic        rd_we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_wdata,
    output logic        inst_v_i,
    output logic        inst_v_x,
    output logic        inst_v_m,
    output logic        inst_v_r,
    output logic [31:0] ci,
    output logic [31:0] cx,
    output logic [31:0] cm,
    output logic [31:0] cr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        rdv,
    output logic [4:0]  rd_x,
    output logic [31:0] rd_data,
    output logic        pcv,
    output logic [31:0] pc_x,
    output logic        ovf_err
`ifdef TRACE_FLUSH_EN
    ,
    output logic        inst_v_f,
    output logic [31:0] cf
`endif
);

    trace_stage_t i_q, x_q, m_q, i_new;
    logic [31:0]  id_q, id_d;
    logic         r_move, m_move, x_move, i_acc, ovf_d;

    // Moves are resolved back to front so a stage vacated this cycle can be
    // refilled in the same cycle. Flush blocks I->X: that entry is killed.
    always_comb begin
        r_move = r_adv & m_q.v;
        m_move = m_adv & x_q.v & (~m_q.v | r_move);
        x_move = x_adv & i_q.v & ~flush & (~x_q.v | m_move);
        i_acc  = i_fire & (~i_q.v | x_move | flush);
        ovf_d  = ovf_err
               | (i_fire & ~i_acc)
               | (x_adv & i_q.v & ~flush & ~x_move)
               | (m_adv & x_q.v & ~m_move);
        id_d   = i_acc ? next_id(id_q) : id_q;
        i_new  = '{v: 1'b1, id: id_q, pc: i_pc, inst: i_inst};
    end

    trace_stage u_stage_i (
        .clk   (clk),
        .rst_n (reset),
        .load_i(i_acc),
        .clr_i (x_move | flush),
        .d_i   (i_new),
        .q_o   (i_q)
    );

    trace_stage u_stage_x (
        .clk   (clk),
        .rst_n (reset),
        .load_i(x_move),
        .clr_i (m_move | flush),
        .d_i   (i_q),
        .q_o   (x_q)
    );

    trace_stage u_stage_m (
        .clk   (clk),
        .rst_n (reset),
        .load_i(m_move),
        .clr_i (r_move),
        .d_i   (x_q),
        .q_o   (m_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_q     <= ID_INIT;
            inst_v_i <= 1'b0;
            inst_v_x <= 1'b0;
            inst_v_m <= 1'b0;
            inst_v_r <= 1'b0;
            ci       <= '0;
            cx       <= '0;
            cm       <= '0;
            cr       <= '0;
            valid    <= 1'b0;
            pc       <= '0;
            inst     <= '0;
            rdv      <= 1'b0;
            rd_x     <= '0;
            rd_data  <= '0;
            pcv      <= 1'b0;
            pc_x     <= '0;
            ovf_err  <= 1'b0;
        end else begin
            id_q     <= id_d;
            ovf_err  <= ovf_d;
            inst_v_i <= i_acc;
            inst_v_x <= x_move;
            inst_v_m <= m_move;
            inst_v_r <= r_move;
            valid    <= r_move;
            rdv      <= r_move & rd_we;
            pcv      <= flush & i_fire;
            if (i_acc)  ci <= id_q;
            if (x_move) cx <= i_q.id;
            if (m_move) cm <= x_q.id;
            if (r_move) begin
                cr      <= m_q.id;
                pc      <= m_q.pc;
                inst    <= m_q.inst;
                rd_x    <= rd_addr;
                rd_data <= rd_wdata;
            end
            if (flush & i_fire) pc_x <= i_pc;
        end
    end

`ifdef TRACE_FLUSH_EN
    logic        kill_x, kill_i;
    logic        pend_v_q, pend_v_d, fv_d;
    logic [31:0] pend_id_q, pend_id_d, fid_d;

    // Killed entries report X first; a second kill waits one cycle in pend.
    // X cannot be valid again in the cycle right after a flush, so one
    // pending slot is always enough.
    always_comb begin
        kill_x    = flush & x_q.v & ~m_move;
        kill_i    = flush & i_q.v;
        fv_d      = 1'b0;
        fid_d     = cf;
        pend_v_d  = 1'b0;
        pend_id_d = pend_id_q;
        if (pend_v_q) begin
            fv_d  = 1'b1;
            fid_d = pend_id_q;
            if (kill_x) begin
                pend_v_d  = 1'b1;
                pend_id_d = x_q.id;
            end else if (kill_i) begin
                pend_v_d  = 1'b1;
                pend_id_d = i_q.id;
            end
        end else if (kill_x) begin
            fv_d  = 1'b1;
            fid_d = x_q.id;
            if (kill_i) begin
                pend_v_d  = 1'b1;
                pend_id_d = i_q.id;
            end
        end else if (kill_i) begin
            fv_d  = 1'b1;
            fid_d = i_q.id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v_q  <= 1'b0;
            pend_id_q <= '0;
            inst_v_f  <= 1'b0;
            cf        <= '0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
            inst_v_f  <= fv_d;
            cf        <= fid_d;
        end
    end
`endif

endmodule

// File: tb/tb_trace_gen.sv
// Directed scoreboard bench for trace_gen; build with TRACE_FLUSH_EN to
// also check the flushed-entry report.
module tb_trace_gen;

    typedef struct {
        logic [31:0] id;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdv;
        logic [4:0]  rdx;
        logic [31:0] rdd;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_fire = 1'b0, x_adv = 1'b0, m_adv = 1'b0, r_adv = 1'b0, flush = 1'b0, rd_we = 1'b0;
    logic [31:0] i_pc = '0, i_inst = '0, rd_wdata = '0;
    logic [4:0]  rd_addr = '0;

    logic        inst_v_i, inst_v_x, inst_v_m, inst_v_r, valid, rdv, pcv, ovf_err;
    logic [31:0] ci, cx, cm, cr, pc, inst, rd_data, pc_x;
    logic [4:0]  rd_x;

    logic        w_inst_v_i, w_inst_v_x, w_inst_v_m, w_inst_v_r, w_valid, w_rdv, w_pcv, w_ovf_err;
    logic [31:0] w_ci, w_cx, w_cm, w_cr, w_pc, w_inst, w_rd_data, w_pc_x;
    logic [4:0]  w_rd_x;
`ifdef TRACE_FLUSH_EN
    logic        inst_v_f, w_inst_v_f;
    logic [31:0] cf, w_cf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_i[$], exp_x[$], exp_m[$], exp_f[$];
    ret_t        exp_r[$];

    always #5 clk = ~clk;

    trace_gen #(.ID_INIT(32'd0)) dut (
        .clk(clk), .reset(reset), .i_fire(i_fire), .i_pc(i_pc), .i_inst(i_inst),
        .x_adv(x_adv), .m_adv(m_adv), .r_adv(r_adv), .flush(flush),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .inst_v_i(inst_v_i), .inst_v_x(inst_v_x), .inst_v_m(inst_v_m), .inst_v_r(inst_v_r),
        .ci(ci), .cx(cx), .cm(cm), .cr(cr),
        .valid(valid), .pc(pc), .inst(inst), .rdv(rdv), .rd_x(rd_x), .rd_data(rd_data),
        .pcv(pcv), .pc_x(pc_x), .ovf_err(ovf_err)
`ifdef TRACE_FLUSH_EN
        , .inst_v_f(inst_v_f), .cf(cf)
`endif
    );

    // Same stimulus, IDs starting at the top of the range.
    trace_gen #(.ID_INIT(32'h7FFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset), .i_fire(i_fire), .i_pc(i_pc), .i_inst(i_inst),
        .x_adv(x_adv), .m_adv(m_adv), .r_adv(r_adv), .flush(flush),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .inst_v_i(w_inst_v_i), .inst_v_x(w_inst_v_x), .inst_v_m(w_inst_v_m), .inst_v_r(w_inst_v_r),
        .ci(w_ci), .cx(w_cx), .cm(w_cm), .cr(w_cr),
        .valid(w_valid), .pc(w_pc), .inst(w_inst), .rdv(w_rdv), .rd_x(w_rd_x), .rd_data(w_rd_data),
        .pcv(w_pcv), .pc_x(w_pc_x), .ovf_err(w_ovf_err)
`ifdef TRACE_FLUSH_EN
        , .inst_v_f(w_inst_v_f), .cf(w_cf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_fire = 1'b0; x_adv = 1'b0; m_adv = 1'b0; r_adv = 1'b0; flush = 1'b0;
        rd_we = 1'b0; rd_addr = '0; rd_wdata = '0; i_pc = '0; i_inst = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_pulses"}, {inst_v_i, inst_v_x, inst_v_m, inst_v_r, valid, rdv, pcv, ovf_err}, 0);
        check({tag, "_ci"}, ci, 0);
        check({tag, "_cx"}, cx, 0);
        check({tag, "_cm"}, cm, 0);
        check({tag, "_cr"}, cr, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_inst"}, inst, 0);
        check({tag, "_pc_x"}, pc_x, 0);
        check({tag, "_rd_x"}, rd_x, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    // Scoreboard: every event pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (inst_v_i === 1'b1) begin
            check("ev_i_expected", exp_i.size() != 0, 1);
            if (exp_i.size() != 0) check("ci", ci, exp_i.pop_front());
        end
        if (inst_v_x === 1'b1) begin
            check("ev_x_expected", exp_x.size() != 0, 1);
            if (exp_x.size() != 0) check("cx", cx, exp_x.pop_front());
        end
        if (inst_v_m === 1'b1) begin
            check("ev_m_expected", exp_m.size() != 0, 1);
            if (exp_m.size() != 0) check("cm", cm, exp_m.pop_front());
        end
        if (inst_v_r === 1'b1) begin
            check("ev_r_expected", exp_r.size() != 0, 1);
            check("valid_with_r", valid, 1);
            if (exp_r.size() != 0) begin
                ret_t e;
                e = exp_r.pop_front();
                check("cr", cr, e.id);
                check("pc", pc, e.pc);
                check("inst", inst, e.inst);
                check("rdv", rdv, e.rdv);
                check("rd_x", rd_x, e.rdx);
                check("rd_data", rd_data, e.rdd);
            end
        end
`ifdef TRACE_FLUSH_EN
        if (inst_v_f === 1'b1) begin
            check("ev_f_expected", exp_f.size() != 0, 1);
            if (exp_f.size() != 0) check("cf", cf, exp_f.pop_front());
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0;
        #12;
        chk_zero("reset");
        cyc();
        reset = 1'b1;
        cyc();

        // single instruction through the whole pipe, with writeback
        idle(); i_fire = 1'b1; i_pc = 32'h100; i_inst = 32'h0050_0093;
        exp_i.push_back(32'd0);
        cyc();
        check("wrap_ci_first", w_ci, 32'h7FFF_FFFF);
        check("wrap_v_i_first", w_inst_v_i, 1);
        idle(); x_adv = 1'b1; exp_x.push_back(32'd0); cyc();
        idle(); m_adv = 1'b1; exp_m.push_back(32'd0); cyc();
        idle(); r_adv = 1'b1; rd_we = 1'b1; rd_addr = 5'd5; rd_wdata = 32'hDEAD_BEEF;
        exp_r.push_back('{id: 32'd0, pc: 32'h100, inst: 32'h0050_0093, rdv: 1'b1, rdx: 5'd5, rdd: 32'hDEAD_BEEF});
        cyc();
        check("retire_valid", valid, 1);
        check("retire_pc", pc, 32'h100);
        idle(); cyc();
        check("valid_low_idle", valid, 0);

        // second fire: wrap instance rolls to 0
        idle(); i_fire = 1'b1; i_pc = 32'h104; i_inst = 32'h0000_0013;
        exp_i.push_back(32'd1);
        cyc();
        check("wrap_ci_second", w_ci, 32'd0);
        check("no_ovf_yet", ovf_err, 0);

        // overflow: fire into occupied I with no x_adv is dropped
        idle(); i_fire = 1'b1; i_pc = 32'h108; cyc();
        check("ovf_set", ovf_err, 1);
        check("dropped_no_v_i", inst_v_i, 0);
        idle(); i_fire = 1'b1; i_pc = 32'h10C; i_inst = 32'h0010_0113; x_adv = 1'b1;
        exp_i.push_back(32'd2);
        exp_x.push_back(32'd1);
        cyc();

        // flush with I=2, X=1 and a redirect target
        idle(); flush = 1'b1; i_fire = 1'b1; i_pc = 32'h200; i_inst = 32'h0000_0293;
        exp_i.push_back(32'd3);
`ifdef TRACE_FLUSH_EN
        exp_f.push_back(32'd1);
        exp_f.push_back(32'd2);
`endif
        cyc();
        check("pcv_on_flush", pcv, 1);
        check("pc_x_on_flush", pc_x, 32'h200);
        idle(); x_adv = 1'b1; exp_x.push_back(32'd3); cyc();
        check("pcv_low_after", pcv, 0);
        check("pc_x_holds", pc_x, 32'h200);
        check("ovf_sticky", ovf_err, 1);
        idle(); m_adv = 1'b1; exp_m.push_back(32'd3); cyc();
        idle(); r_adv = 1'b1; rd_addr = 5'd7; rd_wdata = 32'h1234_5678;
        exp_r.push_back('{id: 32'd3, pc: 32'h200, inst: 32'h0000_0293, rdv: 1'b0, rdx: 5'd7, rdd: 32'h1234_5678});
        cyc();

        // flush without fire and advances into an empty pipe: no events
        idle(); flush = 1'b1; x_adv = 1'b1; m_adv = 1'b1; r_adv = 1'b1; cyc();
        check("pcv_no_fire", pcv, 0);

        // three in flight, then asynchronous reset
        idle(); i_fire = 1'b1; i_pc = 32'h300; exp_i.push_back(32'd4); cyc();
        idle(); i_fire = 1'b1; i_pc = 32'h304; x_adv = 1'b1;
        exp_i.push_back(32'd5); exp_x.push_back(32'd4); cyc();
        idle(); i_fire = 1'b1; i_pc = 32'h308; x_adv = 1'b1; m_adv = 1'b1;
        exp_i.push_back(32'd6); exp_x.push_back(32'd5); exp_m.push_back(32'd4); cyc();
        idle();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_zero("midreset");
        cyc();
        cyc();
        reset = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            idle(); x_adv = 1'b1; m_adv = 1'b1; r_adv = 1'b1; cyc();
        end
        check("post_reset_no_retire", valid, 0);

        idle(); i_fire = 1'b1; i_pc = 32'h400; exp_i.push_back(32'd0); cyc();
        idle(); cyc(); cyc(); cyc();

        check("q_i_drained", exp_i.size(), 0);
        check("q_x_drained", exp_x.size(), 0);
        check("q_m_drained", exp_m.size(), 0);
        check("q_r_drained", exp_r.size(), 0);
`ifdef TRACE_FLUSH_EN
        check("q_f_drained", exp_f.size(), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
